// File: rtl/page_dram_ctrl.sv
// page_dram_ctrl
//   Sequencer between a single-outstanding byte requester and a 16x16x8
//   page-mode DRAM array. One row is kept open between requests. A same-row
//   request goes straight to the access cycle. A row miss first closes the
//   page (PRE) and then opens the new row (ACT). A periodic refresh closes
//   the page and leaves the controller in IDLE.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*             request: valid, we, row, col, wdata
//   o_req_ready         request can be accepted this cycle
//   o_rsp_valid         one-cycle read-data pulse
//   o_rsp_rdata         last read data, held until the next read response
//   o_dram_*            DRAM cs/we/row/col/wdata
//   i_dram_rdata        DRAM data_out
//   o_page_open         a row is open
//   o_open_row          the open row (meaningful when o_page_open)
//
// All outputs are registered. Every output value is computed together with
// the state it belongs to, so each output lines up with its state cycle.
module page_dram_ctrl #(
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 4,
  parameter int T_REFI = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic       i_req_we,
  input  logic [3:0] i_req_row,
  input  logic [3:0] i_req_col,
  input  logic [7:0] i_req_wdata,
  output logic       o_req_ready,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_dram_cs,
  output logic       o_dram_we,
  output logic [3:0] o_dram_row,
  output logic [3:0] o_dram_col,
  output logic [7:0] o_dram_wdata,
  input  logic [7:0] i_dram_rdata,
  output logic       o_page_open,
  output logic [3:0] o_open_row
);

  localparam int WMAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                       : ((T_RP  > T_RFC) ? T_RP  : T_RFC);
  localparam int WW   = $clog2(WMAX + 1);
  localparam int RW   = $clog2(T_REFI);

  typedef enum logic [2:0] {
    S_IDLE, S_OPEN, S_PRE, S_ACT, S_ACC, S_RDCAP, S_REF
  } state_t;

  state_t          r_state;
  logic [WW-1:0]   r_wait;
  logic [RW-1:0]   r_ref_cnt;
  logic            r_ref_pend;
  logic            r_pre_ref;   // current PRE leads into REF instead of ACT
  logic            r_we;
  logic [3:0]      r_row;
  logic [3:0]      r_col;
  logic [7:0]      r_wdata;

  logic w_accept;
  logic w_wrap;
  logic w_wait_done;
  logic w_enter_ref;
  logic w_pend_nx;

  // o_req_ready is only ever 1 in IDLE/OPEN with no refresh pending, so the
  // registered ready is a complete acceptance qualifier.
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_wrap      = (r_ref_cnt == RW'(T_REFI - 1));
  assign w_wait_done = (r_wait == '0);
  assign w_enter_ref = (r_state == S_IDLE && r_ref_pend) ||
                       (r_state == S_PRE && r_pre_ref && w_wait_done);
  // Pending value seen in the next cycle on paths that do not enter REF;
  // a wrap while already pending is simply absorbed.
  assign w_pend_nx   = r_ref_pend || w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_ref_cnt    <= '0;
      r_ref_pend   <= 1'b0;
      r_pre_ref    <= 1'b0;
      r_we         <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_wdata      <= '0;
      o_req_ready  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_dram_cs    <= 1'b0;
      o_dram_we    <= 1'b0;
      o_dram_row   <= '0;
      o_dram_col   <= '0;
      o_dram_wdata <= '0;
      o_page_open  <= 1'b0;
      o_open_row   <= '0;
    end else begin
      r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
      if (w_enter_ref)
        r_ref_pend <= 1'b0;
      else if (w_wrap)
        r_ref_pend <= 1'b1;

      // Pulses and strobes default low; address/data outputs hold.
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_dram_cs   <= 1'b0;
      o_dram_we   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_ref_pend) begin
            r_state <= S_REF;
            r_wait  <= WW'(T_RFC - 1);
          end else if (w_accept) begin
            r_we    <= i_req_we;
            r_row   <= i_req_row;
            r_col   <= i_req_col;
            r_wdata <= i_req_wdata;
            r_state <= S_ACT;
            r_wait  <= WW'(T_RCD - 1);
          end else begin
            o_req_ready <= !w_pend_nx;
          end
        end

        S_OPEN: begin
          if (r_ref_pend) begin
            r_state     <= S_PRE;
            r_pre_ref   <= 1'b1;
            r_wait      <= WW'(T_RP - 1);
            o_page_open <= 1'b0;
          end else if (w_accept) begin
            r_we    <= i_req_we;
            r_row   <= i_req_row;
            r_col   <= i_req_col;
            r_wdata <= i_req_wdata;
            if (i_req_row == o_open_row) begin
              r_state      <= S_ACC;
              o_dram_cs    <= 1'b1;
              o_dram_we    <= i_req_we;
              o_dram_row   <= i_req_row;
              o_dram_col   <= i_req_col;
              o_dram_wdata <= i_req_wdata;
            end else begin
              r_state     <= S_PRE;
              r_pre_ref   <= 1'b0;
              r_wait      <= WW'(T_RP - 1);
              o_page_open <= 1'b0;
            end
          end else begin
            o_req_ready <= !w_pend_nx;
          end
        end

        S_PRE: begin
          if (w_wait_done) begin
            if (r_pre_ref) begin
              r_state <= S_REF;
              r_wait  <= WW'(T_RFC - 1);
            end else begin
              r_state <= S_ACT;
              r_wait  <= WW'(T_RCD - 1);
            end
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end

        S_ACT: begin
          if (w_wait_done) begin
            r_state      <= S_ACC;
            o_page_open  <= 1'b1;
            o_open_row   <= r_row;
            o_dram_cs    <= 1'b1;
            o_dram_we    <= r_we;
            o_dram_row   <= r_row;
            o_dram_col   <= r_col;
            o_dram_wdata <= r_wdata;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end

        S_ACC: begin
          if (r_we) begin
            r_state     <= S_OPEN;
            o_req_ready <= !w_pend_nx;
          end else begin
            // Keep the read selected for the capture cycle; address holds.
            r_state   <= S_RDCAP;
            o_dram_cs <= 1'b1;
          end
        end

        S_RDCAP: begin
          o_rsp_rdata <= i_dram_rdata;
          o_rsp_valid <= 1'b1;
          r_state     <= S_OPEN;
          o_req_ready <= !w_pend_nx;
        end

        S_REF: begin
          if (w_wait_done) begin
            r_state     <= S_IDLE;
            o_req_ready <= !w_pend_nx;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_dram_ctrl.sv
// Self-checking bench for page_dram_ctrl: a table of directed transactions,
// hand-written refresh/reset sequences, and a randomized run checked against
// a flat reference memory and the hit/miss/idle latency rules.
module tb_page_dram_ctrl;

  localparam int T_RCD  = 2;
  localparam int T_RP   = 2;
  localparam int T_RFC  = 4;
  localparam int T_REFI = 64;
  localparam int L_HIT  = 1;
  localparam int L_IDLE = 1 + T_RCD;
  localparam int L_MISS = 1 + T_RP + T_RCD;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we;
  logic [3:0] req_row, req_col;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       dram_cs, dram_we;
  logic [3:0] dram_row, dram_col;
  logic [7:0] dram_wdata;
  logic [7:0] dram_rdata;
  logic       page_open;
  logic [3:0] open_row;

  page_dram_ctrl #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_row(req_row),
    .i_req_col(req_col), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_dram_cs(dram_cs), .o_dram_we(dram_we), .o_dram_row(dram_row),
    .o_dram_col(dram_col), .o_dram_wdata(dram_wdata), .i_dram_rdata(dram_rdata),
    .o_page_open(page_open), .o_open_row(open_row)
  );

  always #5 clk = ~clk;

  // Synchronous-read DRAM array.
  logic [7:0] dmem [256];
  always @(posedge clk) begin
    if (dram_cs) begin
      if (dram_we) dmem[{dram_row, dram_col}] <= dram_wdata;
      else         dram_rdata <= dmem[{dram_row, dram_col}];
    end
  end

  // Reference memory: the contents the requester has written so far.
  logic [7:0] mem_ref [256];

  int total = 0;
  int bad   = 0;
  int cs_seen = 0;
  int cs_exp  = 0;

  always @(negedge clk) if (dram_cs) cs_seen++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ok(input string nm, input bit ok, input int act);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, not an allowed value", nm, act);
    end
  endtask

  // Issue one request starting at a negedge; returns at the negedge where
  // req_ready is seen high again. lat = cycles from acceptance to first cs.
  task automatic do_req(input logic we, input logic [3:0] row, input logic [3:0] col,
                        input logic [7:0] wd, output int wt, output int lat,
                        output int ncs, output int nrsp, output int nbadf,
                        output int nclosed, output logic [7:0] rd);
    wt = 0; lat = -1; ncs = 0; nrsp = 0; nbadf = 0; nclosed = 0; rd = '0;
    cs_exp += we ? 1 : 2;
    req_valid = 1'b1; req_we = we; req_row = row; req_col = col; req_wdata = wd;
    while (!req_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (dram_cs) begin
        ncs++;
        if (lat < 0) lat = k;
        if (dram_row != row || dram_col != col || dram_we != (we && ncs == 1)) nbadf++;
        if (we && dram_wdata != wd) nbadf++;
      end
      if (lat < 0 && !page_open) nclosed++;
      if (rsp_valid) begin
        nrsp++;
        rd = rsp_rdata;
      end
      if (req_ready) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] wd;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wt, lat, ncs, nrsp, nbadf, ncl, n, m;
    logic [7:0] rd;
    logic [3:0] prev;
    bit have_prev;

    for (int i = 0; i < 256; i++) begin
      dmem[i] = '0;
      mem_ref[i] = '0;
    end
    dram_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_row = '0; req_col = '0; req_wdata = '0;

    tbl[0] = '{1'b1, 4'd3, 4'd5, 8'hA5, L_IDLE, 8'h00};
    tbl[1] = '{1'b0, 4'd3, 4'd5, 8'h00, L_HIT,  8'hA5};
    tbl[2] = '{1'b1, 4'd9, 4'd0, 8'h3C, L_MISS, 8'h00};
    tbl[3] = '{1'b0, 4'd9, 4'd0, 8'h00, L_HIT,  8'h3C};
    tbl[4] = '{1'b0, 4'd3, 4'd5, 8'h00, L_MISS, 8'hA5};
    tbl[5] = '{1'b1, 4'd3, 4'd6, 8'h77, L_HIT,  8'h00};
    tbl[6] = '{1'b0, 4'd3, 4'd6, 8'h00, L_HIT,  8'h77};
    tbl[7] = '{1'b0, 4'd9, 4'd0, 8'h00, L_MISS, 8'h3C};

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_cs",    int'(dram_cs), 0);
    chk("rst_rsp",   int'(rsp_valid), 0);
    chk("rst_page",  int'(page_open), 0);
    chk("rst_bus",   int'({dram_we, dram_row, dram_col, dram_wdata, rsp_rdata, open_row}), 0);
    rst = 1'b0;

    // ---- directed table (finishes well before the first refresh)
    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].row, tbl[i].col, tbl[i].wd, wt, lat, ncs, nrsp, nbadf, ncl, rd);
      if (tbl[i].we) mem_ref[{tbl[i].row, tbl[i].col}] = tbl[i].wd;
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_ncs", i), ncs, tbl[i].we ? 1 : 2);
      chk($sformatf("tbl%0d_nrsp", i), nrsp, tbl[i].we ? 0 : 1);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), int'(rd), int'(tbl[i].rd));
      chk($sformatf("tbl%0d_fields", i), nbadf, 0);
      chk($sformatf("tbl%0d_closed", i), ncl, tbl[i].lat - 1);
      chk($sformatf("tbl%0d_page", i), int'(page_open), 1);
      chk($sformatf("tbl%0d_orow", i), int'(open_row), int'(tbl[i].row));
    end

    // ---- refresh from IDLE: ready high T_REFI-1 cycles, then REF closes it
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    while (req_ready && n < 200) begin n++; @(negedge clk); end
    chk("ref_idle_ready_hi", n, T_REFI - 1);
    m = 0;
    while (!req_ready && m < 50) begin m++; @(negedge clk); end
    chk("ref_idle_ready_lo", m, 1 + T_RFC);
    chk("ref_idle_page", int'(page_open), 0);

    // ---- refresh with a page open and a request held throughout
    do_req(1'b1, 4'd5, 4'd1, 8'h11, wt, lat, ncs, nrsp, nbadf, ncl, rd);
    mem_ref[{4'd5, 4'd1}] = 8'h11;
    chk("ref_open_wr_lat", lat, L_IDLE);
    n = 0;
    while (req_ready && n < 200) begin n++; @(negedge clk); end
    chk("ref_open_fall", int'(n < 200), 1);
    do_req(1'b0, 4'd3, 4'd5, 8'h00, wt, lat, ncs, nrsp, nbadf, ncl, rd);
    chk("ref_open_wait", wt, 1 + T_RP + T_RFC);
    chk("ref_open_lat", lat, L_IDLE);
    chk("ref_open_rdata", int'(rd), int'(mem_ref[{4'd3, 4'd5}]));

    // ---- reset during ACT of a read
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_row = 4'd3; req_col = 4'd5;
    n = 0;
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    @(negedge clk);               // ACT cycle
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", int'({req_ready, rsp_valid, dram_cs, dram_we, page_open}), 0);
    chk("midrst_bus", int'({dram_row, dram_col, dram_wdata, rsp_rdata, open_row}), 0);
    rst = 1'b0;
    n = 0; m = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) n++;
      if (dram_cs) m++;
      @(negedge clk);
    end
    chk("midrst_no_rsp", n, 0);
    chk("midrst_no_cs", m, 0);
    do_req(1'b0, 4'd3, 4'd5, 8'h00, wt, lat, ncs, nrsp, nbadf, ncl, rd);
    chk("midrst_next_lat", lat, L_IDLE);
    chk("midrst_next_rdata", int'(rd), int'(mem_ref[{4'd3, 4'd5}]));

    // ---- randomized hits/misses with idle gaps (refresh lands anywhere)
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    have_prev = 1'b0;
    prev = '0;
    for (int t = 0; t < 80; t++) begin
      logic       we;
      logic [3:0] row, col;
      logic [7:0] wd, exp_rd;
      bit         ok;
      we  = 1'($urandom_range(0, 1));
      row = 4'($urandom_range(0, 3));
      col = 4'($urandom_range(0, 15));
      wd  = 8'($urandom);
      exp_rd = mem_ref[{row, col}];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(we, row, col, wd, wt, lat, ncs, nrsp, nbadf, ncl, rd);
      if (!have_prev)       ok = (lat == L_IDLE);
      else if (row == prev) ok = (lat == L_HIT)  || (lat == L_IDLE);
      else                  ok = (lat == L_IDLE) || (lat == L_MISS);
      chk_ok($sformatf("rnd%0d_lat", t), ok, lat);
      chk($sformatf("rnd%0d_ncs", t), ncs, we ? 1 : 2);
      chk($sformatf("rnd%0d_nrsp", t), nrsp, we ? 0 : 1);
      chk($sformatf("rnd%0d_fields", t), nbadf, 0);
      if (!we) chk($sformatf("rnd%0d_rdata", t), int'(rd), int'(exp_rd));
      else     mem_ref[{row, col}] = wd;
      if (page_open) chk($sformatf("rnd%0d_orow", t), int'(open_row), int'(row));
      prev = row;
      have_prev = 1'b1;
    end

    repeat (3) @(negedge clk);
    chk("cs_total", cs_seen, cs_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
